alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits.
REQ-002 Parameter CNT_W, default 8, width of per-requester operation counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 a_valid / b_valid  input  1  requester A/B presents an operation.
REQ-006 a_ready / b_ready  output  1  arbiter accepts requester A/B operation this cycle.
REQ-007 a_op / b_op  input  3  opcode: 000 add, 001 sub, 010 not-A, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
REQ-008 a_x, a_y / b_x, b_y  input  WIDTH  operands of requester A/B.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_id  output  1  0 = result belongs to A, 1 = to B.
REQ-012 rsp_data  output  WIDTH  result.
REQ-013 rsp_carry, rsp_ovf, rsp_zero  output  1 each  carry-out, signed overflow, result-is-zero flags.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 a_count / b_count  output  CNT_W  completed operations per requester.

Function
REQ-016 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-017 IDLE: if exactly one valid, grant it; both valid -> grant requester not granted last (round-robin); none -> stay IDLE.
REQ-018 a_ready/b_ready combinational: high only in IDLE for granted requester; never both high.
REQ-019 Accept cycle (valid && ready): capture op, x, y, id into registers; next state EXEC.
REQ-020 EXEC: shared ALU computes from captured registers; result and flags registered at end of cycle; next state RESP.
REQ-021 RESP: rsp_valid high; rsp_* stable until rsp_ready; on rsp_valid && rsp_ready -> IDLE, last-grant pointer <= rsp_id, count of rsp_id increments.
REQ-022 Latency: accept at cycle T -> rsp_valid first high at T+2; minimum acceptance interval 3 cycles.
REQ-023 Add/sub: WIDTH-bit wrap-around result; carry = bit WIDTH of unsigned sum (sub: x + ~y + 1); ovf = two's-complement overflow.
REQ-024 Logic ops and compares: carry = 0, ovf = 0; compares return 1 or 0 zero-extended to WIDTH.
REQ-025 rsp_zero = (rsp_data == 0) for every op.
REQ-026 Counters saturate at all-ones; no wrap.
REQ-027 Requester deasserting valid before grant has no effect; operands not sampled outside accept cycle.
REQ-028 Inputs in EXEC/RESP ignored; ready low.

Reset
REQ-029 rst asserted at any time forces IDLE immediately; in-flight operation discarded, no response.
REQ-030 Reset values: rsp_valid 0, rsp_id 0, rsp_data 0, all flags 0, busy 0, a_ready/b_ready 0 during reset, counters 0, last-grant pointer = B (A wins first tie).

Structure
REQ-031 Shared package holds opcode constants (OP_ADD..OP_EQ) and FSM state encoding.
REQ-032 One sub-module, alu_core: combinational WIDTH-bit ALU, opcode-to-result selection built on MuxKeyWithDefault (default result 0).
REQ-033 Arbitration, FSM, operand/result registers and counters live in alu_arbiter.

Verification
REQ-034 Reset, a_valid=1 op=000 x=7 y=1, rsp_ready=1 -> a_ready at T, rsp_valid T+2, data=0x8, ovf=1, carry=0, id=0, a_count=1.
REQ-035 Both valid continuously, rsp_ready=1 -> grants alternate A,B,A,B; first A; never both ready.
REQ-036 B op=001 x=3 y=3 -> data=0, zero=1, carry=1; op=110 x=0xF y=0x1 -> data=1.
REQ-037 rsp_ready low 5 cycles in RESP -> rsp_* held stable, no new ready, busy=1; then completes.
REQ-038 rst pulsed in EXEC -> IDLE next edge, no rsp_valid, counters 0.
REQ-039 CNT_W=2, 5 A ops -> a_count stays 3.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants and FSM state encoding for the two-requester ALU arbiter.
package alu_arbiter_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned NUM_OPS = 8;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_NOT = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_OR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR = 3'd5;
    localparam logic [OP_W-1:0] OP_SLT = 3'd6;
    localparam logic [OP_W-1:0] OP_EQ  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// Combinational WIDTH-bit ALU shared by both requesters; flags are only non-zero for add/sub.
module alu_core
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_result_c,
    output logic             o_carry_c,
    output logic             o_ovf_c
);

    localparam int unsigned ENTRY_W = OP_W + WIDTH;

    logic [WIDTH:0]               w_sum;
    logic [WIDTH:0]               w_diff;
    logic                         w_add_ovf;
    logic                         w_sub_ovf;
    logic [WIDTH-1:0]             w_lt;
    logic [WIDTH-1:0]             w_eq;
    logic [NUM_OPS*ENTRY_W-1:0]   w_lut;

    // Subtraction as x + ~y + 1 so carry is the unsigned no-borrow bit.
    assign w_sum     = {1'b0, i_x} + {1'b0, i_y};
    assign w_diff    = {1'b0, i_x} + {1'b0, ~i_y} + (WIDTH+1)'(1);
    assign w_add_ovf = (i_x[WIDTH-1] == i_y[WIDTH-1]) && (w_sum[WIDTH-1]  != i_x[WIDTH-1]);
    assign w_sub_ovf = (i_x[WIDTH-1] != i_y[WIDTH-1]) && (w_diff[WIDTH-1] != i_x[WIDTH-1]);
    assign w_lt      = {{(WIDTH-1){1'b0}}, ($signed(i_x) < $signed(i_y))};
    assign w_eq      = {{(WIDTH-1){1'b0}}, (i_x == i_y)};

    assign w_lut = {
        OP_EQ,  w_eq,
        OP_SLT, w_lt,
        OP_XOR, i_x ^ i_y,
        OP_OR,  i_x | i_y,
        OP_AND, i_x & i_y,
        OP_NOT, ~i_x,
        OP_SUB, w_diff[WIDTH-1:0],
        OP_ADD, w_sum[WIDTH-1:0]
    };

    MuxKeyWithDefault #(
        .NR_KEY   (NUM_OPS),
        .KEY_LEN  (OP_W),
        .DATA_LEN (WIDTH)
    ) u_mux (
        .o_out     (o_result_c),
        .i_key     (i_op),
        .i_default ({WIDTH{1'b0}}),
        .i_lut     (w_lut)
    );

    always_comb begin
        o_carry_c = 1'b0;
        o_ovf_c   = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_carry_c = w_sum[WIDTH];
                o_ovf_c   = w_add_ovf;
            end
            OP_SUB: begin
                o_carry_c = w_diff[WIDTH];
                o_ovf_c   = w_sub_ovf;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mux_key_with_default.sv
// Key-matched selector: returns the data paired with i_key in i_lut, else i_default.
module MuxKeyWithDefault #(
    parameter int unsigned NR_KEY   = 2,
    parameter int unsigned KEY_LEN  = 1,
    parameter int unsigned DATA_LEN = 1
) (
    output logic [DATA_LEN-1:0]                  o_out,
    input  logic [KEY_LEN-1:0]                   i_key,
    input  logic [DATA_LEN-1:0]                  i_default,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] i_lut
);

    localparam int unsigned ENTRY_W = KEY_LEN + DATA_LEN;

    // Each entry is {key, data}; entry 0 sits in the least-significant bits.
    always_comb begin
        o_out = i_default;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            if (i_lut[i*ENTRY_W + DATA_LEN +: KEY_LEN] == i_key) begin
                o_out = i_lut[i*ENTRY_W +: DATA_LEN];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that serialises two requesters through one registered ALU pass
// (IDLE -> EXEC -> RESP) and counts completed operations per requester.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [OP_W-1:0]  a_op,
    input  logic [WIDTH-1:0] a_x,
    input  logic [WIDTH-1:0] a_y,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [OP_W-1:0]  b_op,
    input  logic [WIDTH-1:0] b_x,
    input  logic [WIDTH-1:0] b_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_ovf,
    output logic             rsp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    state_t           r_state;
    state_t           w_next;
    logic [OP_W-1:0]  r_op;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_id;
    logic             r_last;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_carry;
    logic             r_rsp_ovf;
    logic             r_rsp_zero;
    logic [CNT_W-1:0] r_a_count;
    logic [CNT_W-1:0] r_b_count;

    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_accept;
    logic             w_done;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic             w_alu_ovf;

    // r_last = 1 means B was served last, so A wins the next tie.
    assign w_grant_b = b_valid && (!a_valid || !r_last);
    assign w_grant_a = a_valid && !w_grant_b;
    assign w_accept  = (r_state == ST_IDLE) && (w_grant_a || w_grant_b);
    assign w_done    = (r_state == ST_RESP) && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                a_ready = !rst && w_grant_a;
                b_ready = !rst && w_grant_b;
                if (w_grant_a || w_grant_b) begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .i_op       (r_op),
        .i_x        (r_x),
        .i_y        (r_y),
        .o_result_c (w_alu_result),
        .o_carry_c  (w_alu_carry),
        .o_ovf_c    (w_alu_ovf)
    );

    // Operand capture, result registration and completion bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= OP_ADD;
            r_x         <= '0;
            r_y         <= '0;
            r_id        <= 1'b0;
            r_last      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_a_count   <= '0;
            r_b_count   <= '0;
        end else begin
            if (w_accept) begin
                r_op <= w_grant_b ? b_op : a_op;
                r_x  <= w_grant_b ? b_x  : a_x;
                r_y  <= w_grant_b ? b_y  : a_y;
                r_id <= w_grant_b;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_data  <= w_alu_result;
                r_rsp_carry <= w_alu_carry;
                r_rsp_ovf   <= w_alu_ovf;
                r_rsp_zero  <= (w_alu_result == '0);
            end
            if (w_done) begin
                r_rsp_valid <= 1'b0;
                r_last      <= r_rsp_id;
                if (!r_rsp_id && (r_a_count != {CNT_W{1'b1}})) begin
                    r_a_count <= r_a_count + CNT_W'(1);
                end
                if (r_rsp_id && (r_b_count != {CNT_W{1'b1}})) begin
                    r_b_count <= r_b_count + CNT_W'(1);
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;
    assign rsp_ovf   = r_rsp_ovf;
    assign rsp_zero  = r_rsp_zero;
    assign busy      = (r_state != ST_IDLE);
    assign a_count   = r_a_count;
    assign b_count   = r_b_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, latency, round-robin, ALU ops, stall, reset abort, saturation.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic       a_valid, b_valid, rsp_ready;
    logic       a_ready, b_ready;
    logic [2:0] a_op, b_op;
    logic [3:0] a_x, a_y, b_x, b_y;
    logic       rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_zero, busy;
    logic [3:0] rsp_data;
    logic [7:0] a_count, b_count;

    logic       a2_valid, a2_ready, b2_ready, rsp2_valid, rsp2_id;
    logic       rsp2_carry, rsp2_ovf, rsp2_zero, busy2;
    logic [3:0] rsp2_data;
    logic [1:0] a2_count, b2_count;
    logic       c_zero;
    logic [2:0] c_op_add;
    logic [3:0] c_one;

    int n_checks = 0;
    int n_errors = 0;
    int ea = 0;
    int eb = 0;

    alu_arbiter #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_x(a_x), .a_y(a_y),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_x(b_x), .b_y(b_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .busy(busy),
        .a_count(a_count), .b_count(b_count)
    );

    alu_arbiter #(.WIDTH(4), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst),
        .a_valid(a2_valid), .a_ready(a2_ready), .a_op(c_op_add), .a_x(c_one), .a_y(c_one),
        .b_valid(c_zero), .b_ready(b2_ready), .b_op(c_op_add), .b_x(c_one), .b_y(c_one),
        .rsp_valid(rsp2_valid), .rsp_ready(1'b1), .rsp_id(rsp2_id), .rsp_data(rsp2_data),
        .rsp_carry(rsp2_carry), .rsp_ovf(rsp2_ovf), .rsp_zero(rsp2_zero), .busy(busy2),
        .a_count(a2_count), .b_count(b2_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated transaction: grant at T, EXEC at T+1, response at T+2, done at T+3.
    task automatic do_op(input bit use_b, input logic [2:0] op, input logic [3:0] x,
                         input logic [3:0] y, input logic [3:0] e_d,
                         input bit e_c, input bit e_o, input bit e_z);
        int n = 0;
        if (use_b) begin
            b_valid = 1'b1; b_op = op; b_x = x; b_y = y;
        end else begin
            a_valid = 1'b1; a_op = op; a_x = x; a_y = y;
        end
        rsp_ready = 1'b1;
        #1;
        while (!(use_b ? b_ready : a_ready) && n < 8) begin
            tick();
            n++;
        end
        chk("op_grant", 32'(use_b ? b_ready : a_ready), 32'd1);
        chk("op_grant_excl", 32'(use_b ? a_ready : b_ready), 32'd0);
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_op = ~op; b_op = ~op; a_x = ~x; b_x = ~x; a_y = ~y; b_y = ~y;
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(use_b));
        chk("rsp_data", 32'(rsp_data), 32'(e_d));
        chk("rsp_carry", 32'(rsp_carry), 32'(e_c));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(e_o));
        chk("rsp_zero", 32'(rsp_zero), 32'(e_z));
        tick();
        if (use_b) eb++; else ea++;
        chk("done_rsp_low", 32'(rsp_valid), 32'd0);
        chk("a_count", 32'(a_count), 32'(ea));
        chk("b_count", 32'(b_count), 32'(eb));
    endtask

    initial begin
        int n;
        int hs;
        c_zero = 1'b0; c_op_add = 3'b000; c_one = 4'h1;
        rst = 1'b1; a2_valid = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; rsp_ready = 1'b1;
        a_op = 3'b000; b_op = 3'b000; a_x = 4'h7; a_y = 4'h1; b_x = 4'h0; b_y = 4'h0;
        tick();
        tick();

        // Reset values
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_flags", 32'({rsp_carry, rsp_ovf, rsp_zero}), 32'd0);
        chk("rst_counts", 32'({a_count, b_count}), 32'd0);

        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b0;
        tick();

        // 7 + 1 overflows into the sign bit
        do_op(1'b0, 3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0);

        // Fresh reset, then both requesters contend continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ea = 0; eb = 0;
        a_valid = 1'b1; a_op = 3'b101; a_x = 4'h5; a_y = 4'h3;
        b_valid = 1'b1; b_op = 3'b001; b_x = 4'h3; b_y = 4'h3;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(a_ready || b_ready) && n < 8) begin
                tick();
                n++;
            end
            chk("rr_excl", 32'(a_ready && b_ready), 32'd0);
            chk("rr_grant_b", 32'(b_ready), 32'(g % 2));
            chk("rr_grant_a", 32'(a_ready), 32'((g + 1) % 2));
            @(posedge clk);
            #1;
            chk("rr_exec_ready", 32'(a_ready || b_ready), 32'd0);
            tick();
            chk("rr_rsp_id", 32'(rsp_id), 32'(g % 2));
            chk("rr_rsp_data", 32'(rsp_data), (g % 2 == 1) ? 32'h0 : 32'h6);
            chk("rr_rsp_zero", 32'(rsp_zero), 32'(g % 2));
            chk("rr_rsp_carry", 32'(rsp_carry), 32'(g % 2));
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        ea = 2; eb = 2;
        chk("rr_a_count", 32'(a_count), 32'd2);
        chk("rr_b_count", 32'(b_count), 32'd2);
        tick();

        // Directed ALU vectors: requester, op, x, y, data, carry, ovf, zero
        do_op(1'b1, 3'b110, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 3'b001, 4'h3, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1);
        do_op(1'b0, 3'b001, 4'h8, 4'h1, 4'h7, 1'b1, 1'b1, 1'b0);
        do_op(1'b1, 3'b000, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1);
        do_op(1'b0, 3'b010, 4'hA, 4'h6, 4'h5, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 3'b100, 4'hC, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 3'b111, 4'h5, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 3'b111, 4'h5, 4'h4, 4'h0, 1'b0, 1'b0, 1'b1);
        do_op(1'b0, 3'b110, 4'h1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1);

        // Response back-pressure: outputs held, no new grant
        a_valid = 1'b1; a_op = 3'b011; a_x = 4'hC; a_y = 4'hA;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        tick();
        a_valid = 1'b1; b_valid = 1'b1; a_x = 4'h0; b_x = 4'h0;
        for (int s = 0; s < 5; s++) begin
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_data", 32'(rsp_data), 32'h8);
            chk("stall_rsp_id", 32'(rsp_id), 32'd0);
            chk("stall_no_ready", 32'(a_ready || b_ready), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        ea++;
        chk("stall_done", 32'(rsp_valid), 32'd0);
        chk("stall_a_count", 32'(a_count), 32'(ea));

        // Reset during EXEC discards the operation
        a_valid = 1'b1; a_op = 3'b000; a_x = 4'h1; a_y = 4'h1;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        chk("abort_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy_now", 32'(busy), 32'd0);
        chk("abort_rsp_now", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("abort_counts", 32'({a_count, b_count}), 32'd0);
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("abort_tie_a", 32'(a_ready), 32'd1);
        chk("abort_tie_b", 32'(b_ready), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        // Two-bit counter saturates at 3 after five completions
        a2_valid = 1'b1;
        hs = 0;
        n = 0;
        while (hs < 5 && n < 60) begin
            tick();
            n++;
            if (rsp2_valid) hs++;
        end
        a2_valid = 1'b0;
        tick();
        tick();
        chk("sat_handshakes", 32'(hs), 32'd5);
        chk("sat_a_count", 32'(a2_count), 32'd3);
        chk("sat_b_count", 32'(b2_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
